// File: rtl/max_loc_sched.sv
// Round-robin scheduler that shares one signed max/location comparator among NUM_PU requesters.
// States: IDLE (waiting for start) | RUN (granting) | DRAIN (last stage compare) | DONE (result valid, done pulse).
module max_loc_sched #(
  parameter int NUM_PU         = 16,
  parameter int CMP_WIDTH      = 16,
  parameter int LOCATION_WIDTH = 32
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst,
  input  logic                             start,
  input  logic                             mode_in,
  input  logic                             finish,
  input  logic [NUM_PU-1:0]                req,
  input  logic [NUM_PU*CMP_WIDTH-1:0]      score_in,
  input  logic [NUM_PU*LOCATION_WIDTH-1:0] loc_in,
  output logic [NUM_PU-1:0]                gnt,
  output logic                             busy,
  output logic                             done,
  output logic signed [CMP_WIDTH-1:0]      max_out,
  output logic [LOCATION_WIDTH-1:0]        loc_out,
  output logic [15:0]                      cmp_count
);

  localparam int IDX_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            rr_ptr;
  logic [IDX_W-1:0]            gnt_idx;
  logic                        gnt_vld;
  logic                        start_acc;
  logic                        stage_vld;
  logic signed [CMP_WIDTH-1:0] stage_score;
  logic [LOCATION_WIDTH-1:0]   stage_loc;

  // start only counts where a new alignment may begin
  assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)  state_d = S_RUN;
      S_RUN:   if (finish) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // first set request at or above the pointer, wrapping
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (state_q == S_RUN) begin
      for (int k = 0; k < NUM_PU; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_PU;
        if (!gnt_vld && req[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = IDX_W'(idx);
        end
      end
    end
    gnt = gnt_vld ? (NUM_PU'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rr_ptr      <= '0;
      stage_vld   <= 1'b0;
      stage_score <= '0;
      stage_loc   <= '0;
      cmp_count   <= '0;
    end else begin
      stage_vld <= gnt_vld;
      if (gnt_vld) begin
        stage_score <= score_in[gnt_idx*CMP_WIDTH +: CMP_WIDTH];
        stage_loc   <= loc_in[gnt_idx*LOCATION_WIDTH +: LOCATION_WIDTH];
        rr_ptr      <= (gnt_idx == IDX_W'(NUM_PU - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (start_acc)
        cmp_count <= '0;
      else if (gnt_vld && (cmp_count != 16'hFFFF))
        cmp_count <= cmp_count + 16'd1;
    end
  end

  // strict signed compare keeps the earlier-granted entry on ties
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      max_out <= '0;
      loc_out <= '0;
    end else if (start_acc && !mode_in) begin
      max_out <= '0;
      loc_out <= '0;
    end else if (stage_vld && (stage_score > max_out)) begin
      max_out <= stage_score;
      loc_out <= stage_loc;
    end
  end

endmodule
